// File: rtl/div32_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div32_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        CALC,
        SIGN,
        DONE
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;
    localparam logic [DIV_WIDTH-1:0] INT_MIN   = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div32_if.sv
// Start/done handshake and operand/result bundle between the execute path and the divider.
interface div32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div32_step.sv
// One restoring-division iteration: shift {rem,q} left and try to subtract the divisor.
module div32_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_restore;

    // The shifted remainder is below 2*divisor, so the top difference bit alone flags a negative trial.
    assign w_shift   = {i_rem, i_q[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, i_dvs};
    assign w_restore = w_diff[WIDTH];

    assign o_rem = w_restore ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_q   = {i_q[WIDTH-2:0], ~w_restore};
endmodule

// File: rtl/div32_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle, start/done handshake.
// Signed support is built only when DIV32_SIGNED_EN is defined; otherwise every divide is unsigned.
module div32_seq
    import div32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    div32_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_quot_fin;
    logic [WIDTH-1:0] w_rem_fin;
    logic             w_ovf_fin;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;
    logic             r_ovf_o;

`ifdef DIV32_SIGNED_EN
    logic r_qneg;
    logic r_rneg;
    logic r_ovf;
    logic w_sop;
    logic w_ovf;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? ((~v) + WIDTH'(1)) : v;
    endfunction

    assign w_sop     = bus.signed_op;
    assign w_dvd_mag = neg_if(bus.dividend, w_sop & bus.dividend[WIDTH-1]);
    assign w_dvs_mag = neg_if(bus.divisor,  w_sop & bus.divisor[WIDTH-1]);
    // INT_MIN / -1 falls out of the magnitude path as 2^(WIDTH-1); only the flag needs detecting.
    assign w_ovf     = w_sop && (bus.dividend == INT_MIN) && (bus.divisor == DIV0_QUOT);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_qneg <= w_sop & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_rneg <= w_sop & bus.dividend[WIDTH-1];
            r_ovf  <= w_ovf;
        end
    end

    assign w_quot_fin = neg_if(r_q, r_qneg);
    assign w_rem_fin  = neg_if(r_rem, r_rneg);
    assign w_ovf_fin  = r_ovf;
`else
    logic w_unused_signed;

    assign w_unused_signed = bus.signed_op;
    assign w_dvd_mag       = bus.dividend;
    assign w_dvs_mag       = bus.divisor;
    assign w_quot_fin      = r_q;
    assign w_rem_fin       = r_rem;
    assign w_ovf_fin       = 1'b0;
`endif

    div32_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_q   (r_q),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nx),
        .o_q   (w_q_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = (bus.divisor == '0) ? ZERO : CALC;
                end
            end
            ZERO:    w_next = DONE;
            CALC:    if (r_count == '0) w_next = SIGN;
            SIGN:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // For a zero divisor r_q carries the raw dividend so ZERO can return it untouched.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rem   <= '0;
            r_q     <= (bus.divisor == '0) ? bus.dividend : w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_count <= CNT_W'(WIDTH - 1);
        end else if (r_state == CALC) begin
            r_rem   <= w_rem_nx;
            r_q     <= w_q_nx;
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
            r_ovf_o <= 1'b0;
        end else if (r_state == ZERO) begin
            r_quot  <= DIV0_QUOT;
            r_remo  <= r_q;
            r_dbz   <= 1'b1;
            r_ovf_o <= 1'b0;
        end else if (r_state == SIGN) begin
            r_quot  <= w_quot_fin;
            r_remo  <= w_rem_fin;
            r_dbz   <= 1'b0;
            r_ovf_o <= w_ovf_fin;
        end
    end

    assign bus.busy        = (r_state == ZERO) || (r_state == CALC) || (r_state == SIGN);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf_o;
endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: vector table plus scoreboard, with hand sequences for abort and ignored start.
module tb_div32_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_done = 0;

    div32_if #(.WIDTH(32)) bus ();

    div32_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          acc;
        int          lat;
        int          id;
    } exp_t;

    typedef struct {
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    exp_t sb[$];
    vec_t vt[NV];

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s id=%0d got=%h want=%h", nm, id, act, exp);
        end
    endtask

    // Scoreboard monitor: results, flags and latency at done; busy while an op is outstanding.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("spurious_done", -1, 32'(bus.done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", e.id, bus.quotient, e.q);
                    chk("remainder", e.id, bus.remainder, e.r);
                    chk("div_by_zero", e.id, 32'(bus.div_by_zero), 32'(e.dz));
                    chk("overflow", e.id, 32'(bus.overflow), 32'(e.ov));
                    chk("latency", e.id, 32'(cyc - e.acc), 32'(e.lat));
                    chk("busy_at_done", e.id, 32'(bus.busy), 32'd0);
                end
            end else if (sb.size() != 0 && !rst) begin
                e = sb[0];
                chk("busy", e.id, 32'(bus.busy), 32'((cyc > e.acc) && (cyc < e.acc + e.lat)));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", -1, 32'(bus.busy), 32'd0);
    endtask

    task automatic drive(input logic sop, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.signed_op = sop;
        bus.dividend  = a;
        bus.divisor   = b;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb[0].id, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input int id, input vec_t v);
        exp_t e;
        wait_idle();
        drive(v.sop, v.a, v.b);
        e.q = v.q; e.r = v.r; e.dz = v.dz; e.ov = v.ov;
        e.acc = cyc; e.lat = v.lat; e.id = id;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
    endtask

    initial begin
        vec_t v;
        int   n0;
        int   acc;

        vt[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34};
`ifdef DIV32_SIGNED_EN
        vt[1]  = '{1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
        vt[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 1'b1, 34};
        vt[7]  = '{1'b1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 1'b0, 1'b0, 34};
        vt[11] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0, 34};
`else
        vt[1]  = '{1'b1, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC, 32'h1, 1'b0, 1'b0, 34};
        vt[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0, 34};
        vt[7]  = '{1'b1, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h7, 1'b0, 1'b0, 34};
        vt[11] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0, 32'hFFFFFF9C, 1'b0, 1'b0, 34};
`endif
        vt[2]  = '{1'b0, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1'b0, 2};
        vt[4]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0, 34};
        vt[5]  = '{1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 34};
        vt[6]  = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 34};
        vt[8]  = '{1'b1, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1, 1'b0, 2};
        vt[9]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 34};
        vt[10] = '{1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 1'b0, 34};
        vt[12] = '{1'b0, 32'hDEADBEEF, 32'h1000, 32'h000DEADB, 32'hEEF, 1'b0, 1'b0, 34};

        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", -1, 32'(bus.busy), 32'd0);
        chk("rst_done", -1, 32'(bus.done), 32'd0);
        chk("rst_quot", -1, bus.quotient, 32'd0);
        chk("rst_rem", -1, bus.remainder, 32'd0);

        for (int i = 0; i < NV; i++) do_op(i, vt[i]);

        repeat (3) @(negedge clk);
        chk("hold_quot", 12, bus.quotient, vt[NV-1].q);
        chk("hold_rem", 12, bus.remainder, vt[NV-1].r);

        // Start during busy must be ignored and must not disturb held or pending results.
        n0 = n_done;
        wait_idle();
        drive(1'b0, 32'd100, 32'd7);
        sb.push_back('{32'd14, 32'd2, 1'b0, 1'b0, cyc, 34, 100});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_after_accept", 100, bus.quotient, vt[NV-1].q);
        drive(1'b0, 32'd9, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);
        chk("single_done", 100, 32'(n_done - n0), 32'd1);

        // Reset mid-operation aborts with no done pulse.
        wait_idle();
        drive(1'b0, 32'hFFFFFFFF, 32'h1);
        acc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < acc + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 101, 32'(bus.busy), 32'd0);
        chk("abort_done", 101, 32'(bus.done), 32'd0);
        chk("abort_quot", 101, bus.quotient, 32'd0);
        chk("abort_rem", 101, bus.remainder, 32'd0);
        chk("abort_dbz", 101, 32'(bus.div_by_zero), 32'd0);
        chk("abort_ovf", 101, 32'(bus.overflow), 32'd0);
        n0 = n_done;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", 101, 32'(n_done - n0), 32'd0);
        v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 34};
        do_op(102, v);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog id=-1 got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
